// File: rtl/wb_queue.sv
// In-order writeback completion queue: retires ALU results, loads, branches and jumps.
// Latency: one cycle from queue entry to wb_*/redir_*; loads wait at the head for mem_rvalid.
// Backpressure: in_ready drops only when all DEPTH entries are occupied.

module wb_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    input  logic             clr,
    output logic [WIDTH-1:0] head_dat,
    output logic             full,
    output logic             empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign head_dat = mem[head];
    // A clear drops the queue contents and any push presented alongside it.
    assign do_push  = push && !full && !clr;
    assign do_pop   = pop && !empty;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[tail] <= push_dat;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (clr) begin
            head  <= tail;
            count <= '0;
        end else begin
            if (do_push) begin
                tail <= tail + PW'(1);
            end
            if (do_pop) begin
                head <= head + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

module wb_queue #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4,
    parameter int RAW   = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [1:0]                in_op,
    input  logic [3:0]                in_spec,
    input  logic [RAW-1:0]            in_rd,
    input  logic [XLEN-1:0]           in_res,
    input  logic [$clog2(XLEN/8)-1:0] in_off,
    input  logic                      in_jmp_tk,
    input  logic [XLEN-1:0]           in_jmp_addr,
    input  logic                      mem_rvalid,
    output logic                      mem_rready,
    input  logic [XLEN-1:0]           mem_rdata,
    output logic                      wb_en,
    output logic [RAW-1:0]            wb_rd,
    output logic [XLEN-1:0]           wb_dat,
    output logic                      redir_valid,
    output logic [XLEN-1:0]           redir_addr,
    output logic                      flush_out,
    output logic                      misalign_err
);
    localparam int OFFW = $clog2(XLEN / 8);

    typedef enum logic [1:0] {
        OP_ARITH  = 2'd0,
        OP_MEM    = 2'd1,
        OP_BRANCH = 2'd2,
        OP_JUMP   = 2'd3
    } op_e;

    typedef struct packed {
        op_e             op;
        logic [3:0]      spec;
        logic [RAW-1:0]  rd;
        logic [XLEN-1:0] res;
        logic [OFFW-1:0] off;
        logic            jmp_tk;
        logic [XLEN-1:0] jmp_addr;
    } entry_t;

    entry_t          push_ent;
    entry_t          head;
    logic            full;
    logic            empty;
    logic            head_is_load;
    logic            retire;

    logic [2:0]      f3;
    logic            load_sgn;
    logic            load_bad;
    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] load_dat;

    logic            nx_wb_en;
    logic [XLEN-1:0] nx_wb_dat;
    logic            nx_redir;
    logic            nx_mis;

    assign push_ent = '{op_e'(in_op), in_spec, in_rd, in_res, in_off, in_jmp_tk, in_jmp_addr};

    wb_fifo #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (in_valid),
        .push_dat (push_ent),
        .pop      (retire),
        .clr      (nx_redir),
        .head_dat (head),
        .full     (full),
        .empty    (empty)
    );

    assign in_ready     = !full;
    assign head_is_load = (head.op == OP_MEM) && !head.spec[3];
    assign mem_rready   = !empty && head_is_load;
    assign retire       = !empty && (!head_is_load || mem_rvalid);

    // Byte-lane select, then size/sign handling keyed on funct3.
    always_comb begin
        f3       = head.spec[2:0];
        load_sgn = !f3[2];
        shifted  = mem_rdata >> {head.off, 3'b000};
        load_bad = 1'b0;
        load_dat = shifted;
        case (f3[1:0])
            2'b00: begin
                load_dat = load_sgn ? XLEN'($signed(shifted[7:0])) : XLEN'(shifted[7:0]);
            end
            2'b01: begin
                load_bad = head.off[0];
                load_dat = load_sgn ? XLEN'($signed(shifted[15:0])) : XLEN'(shifted[15:0]);
            end
            2'b10: begin
                load_bad = (head.off[1:0] != 2'b00);
                load_dat = load_sgn ? XLEN'($signed(shifted[31:0])) : XLEN'(shifted[31:0]);
            end
            default: begin
                load_bad = f3[2] || (XLEN != 64) || (head.off != '0);
                load_dat = shifted;
            end
        endcase
    end

    always_comb begin
        nx_wb_en  = 1'b0;
        nx_wb_dat = head.res;
        nx_redir  = 1'b0;
        nx_mis    = 1'b0;
        if (retire) begin
            case (head.op)
                OP_ARITH: nx_wb_en = (head.rd != '0);
                OP_MEM: begin
                    if (head_is_load) begin
                        if (load_bad) begin
                            nx_mis = 1'b1;
                        end else begin
                            nx_wb_en  = (head.rd != '0);
                            nx_wb_dat = load_dat;
                        end
                    end
                end
                OP_BRANCH: nx_redir = head.jmp_tk;
                default: begin
                    nx_wb_en = (head.rd != '0);
                    nx_redir = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_en        <= 1'b0;
            wb_rd        <= '0;
            wb_dat       <= '0;
            redir_valid  <= 1'b0;
            redir_addr   <= '0;
            flush_out    <= 1'b0;
            misalign_err <= 1'b0;
        end else begin
            wb_en        <= nx_wb_en;
            redir_valid  <= nx_redir;
            flush_out    <= nx_redir;
            misalign_err <= nx_mis;
            if (nx_wb_en) begin
                wb_rd  <= head.rd;
                wb_dat <= nx_wb_dat;
            end
            if (nx_redir) begin
                redir_addr <= head.jmp_addr;
            end
        end
    end
endmodule

// File: tb/tb_wb_queue.sv
// Self-checking bench for wb_queue: directed scenarios then random traffic,
// all compared against a queue-based behavioural model.
module tb_wb_queue;
    localparam int XLEN  = 32;
    localparam int DEPTH = 4;
    localparam int RAW   = 5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  in_op = '0;
    logic [3:0]  in_spec = '0;
    logic [4:0]  in_rd = '0;
    logic [31:0] in_res = '0;
    logic [1:0]  in_off = '0;
    logic        in_jmp_tk = 1'b0;
    logic [31:0] in_jmp_addr = '0;
    logic        mem_rvalid = 1'b0;
    logic        mem_rready;
    logic [31:0] mem_rdata = '0;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_dat;
    logic        redir_valid;
    logic [31:0] redir_addr;
    logic        flush_out;
    logic        misalign_err;

    wb_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .RAW(RAW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_spec(in_spec),
        .in_rd(in_rd), .in_res(in_res), .in_off(in_off), .in_jmp_tk(in_jmp_tk),
        .in_jmp_addr(in_jmp_addr), .mem_rvalid(mem_rvalid), .mem_rready(mem_rready),
        .mem_rdata(mem_rdata), .wb_en(wb_en), .wb_rd(wb_rd), .wb_dat(wb_dat),
        .redir_valid(redir_valid), .redir_addr(redir_addr), .flush_out(flush_out),
        .misalign_err(misalign_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [3:0]  spec;
        logic [4:0]  rd;
        logic [31:0] res;
        logic [1:0]  off;
        logic        tk;
        logic [31:0] addr;
    } ent_t;

    ent_t        q[$];
    int          errors = 0;
    int          checks = 0;
    logic        e_wb_en = 1'b0;
    logic        e_redir = 1'b0;
    logic        e_mis = 1'b0;
    logic [4:0]  e_rd = '0;
    logic [31:0] e_dat = '0;
    logic [31:0] e_addr = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic is_load(input ent_t e);
        return (e.op == 2'd1) && !e.spec[3];
    endfunction

    function automatic logic load_bad(input ent_t e);
        int sz;
        if (e.spec[2:0] == 3'd3 || e.spec[2:0] == 3'd7) return 1'b1;
        sz = 1 << e.spec[1:0];
        return (int'(e.off) % sz) != 0;
    endfunction

    function automatic logic [31:0] load_val(input ent_t e, input logic [31:0] w);
        int     nb;
        longint v;
        nb = 8 << e.spec[1:0];
        v  = longint'({32'b0, w} >> (8 * int'(e.off)));
        v  = v & ((64'sd1 <<< nb) - 64'sd1);
        if (!e.spec[2] && v[nb-1]) v = v - (64'sd1 <<< nb);
        return v[31:0];
    endfunction

    task automatic check_outputs();
        check("in_ready", in_ready, q.size() < DEPTH);
        check("mem_rready", mem_rready, q.size() > 0 && is_load(q[0]));
        check("wb_en", wb_en, e_wb_en);
        if (e_wb_en) begin
            check("wb_rd", wb_rd, e_rd);
            check("wb_dat", wb_dat, e_dat);
        end
        check("redir_valid", redir_valid, e_redir);
        check("flush_out", flush_out, e_redir);
        if (e_redir) check("redir_addr", redir_addr, e_addr);
        check("misalign_err", misalign_err, e_mis);
    endtask

    // Drives one cycle of inputs, advances the model, then checks after the edge.
    task automatic cycle(input logic v, input ent_t e, input logic rv, input logic [31:0] rdat);
        ent_t h;
        logic ret;
        logic can_push;
        in_valid = v; in_op = e.op; in_spec = e.spec; in_rd = e.rd; in_res = e.res;
        in_off = e.off; in_jmp_tk = e.tk; in_jmp_addr = e.addr;
        mem_rvalid = rv; mem_rdata = rdat;
        e_wb_en = 1'b0; e_redir = 1'b0; e_mis = 1'b0;
        can_push = q.size() < DEPTH;
        ret = 1'b0;
        if (q.size() > 0) begin
            h = q[0];
            ret = !is_load(h) || rv;
        end
        if (ret) begin
            case (h.op)
                2'd0: begin e_wb_en = h.rd != 0; e_rd = h.rd; e_dat = h.res; end
                2'd1: if (is_load(h)) begin
                    if (load_bad(h)) e_mis = 1'b1;
                    else begin e_wb_en = h.rd != 0; e_rd = h.rd; e_dat = load_val(h, rdat); end
                end
                2'd2: begin e_redir = h.tk; e_addr = h.addr; end
                default: begin
                    e_wb_en = h.rd != 0; e_rd = h.rd; e_dat = h.res;
                    e_redir = 1'b1; e_addr = h.addr;
                end
            endcase
        end
        if (e_redir) q.delete();
        else begin
            if (ret) void'(q.pop_front());
            if (v && can_push) q.push_back(e);
        end
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #2;
        q.delete();
        e_wb_en = 1'b0; e_redir = 1'b0; e_mis = 1'b0;
        check_outputs();
        check("rst_wb_rd", wb_rd, 0);
        check("rst_wb_dat", wb_dat, 0);
        check("rst_redir_addr", redir_addr, 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic ent_t mk(input logic [1:0] op, input logic [3:0] spec, input logic [4:0] rd,
                                input logic [31:0] res, input logic [1:0] off, input logic tk,
                                input logic [31:0] addr);
        ent_t e;
        e.op = op; e.spec = spec; e.rd = rd; e.res = res; e.off = off; e.tk = tk; e.addr = addr;
        return e;
    endfunction

    initial begin
        ent_t idle;
        ent_t ld;
        ent_t r;
        idle = mk(2'd0, 4'd0, 5'd0, 32'd0, 2'd0, 1'b0, 32'd0);
        #1;
        do_reset();

        cycle(1'b1, mk(2'd0, 4'd0, 5'd5, 32'h1234, 2'd0, 1'b0, 32'd0), 1'b0, 32'd0);
        cycle(1'b0, idle, 1'b0, 32'd0);
        check("arith_en", wb_en, 1);
        check("arith_rd", wb_rd, 5);
        check("arith_dat", wb_dat, 32'h0000_1234);
        cycle(1'b1, mk(2'd0, 4'd0, 5'd0, 32'h1234, 2'd0, 1'b0, 32'd0), 1'b0, 32'd0);
        cycle(1'b0, idle, 1'b0, 32'd0);
        check("x0_en", wb_en, 0);

        cycle(1'b1, mk(2'd1, 4'b0000, 5'd3, 32'd0, 2'd2, 1'b0, 32'd0), 1'b0, 32'd0);
        cycle(1'b0, idle, 1'b1, 32'h1180_2233);
        check("lb_dat", wb_dat, 32'hFFFF_FF80);
        cycle(1'b1, mk(2'd1, 4'b0100, 5'd3, 32'd0, 2'd2, 1'b0, 32'd0), 1'b0, 32'd0);
        cycle(1'b0, idle, 1'b1, 32'h1180_2233);
        check("lbu_dat", wb_dat, 32'h0000_0080);
        cycle(1'b1, mk(2'd1, 4'b0101, 5'd3, 32'd0, 2'd2, 1'b0, 32'd0), 1'b0, 32'd0);
        cycle(1'b0, idle, 1'b1, 32'h1180_2233);
        check("lhu_dat", wb_dat, 32'h0000_1180);

        cycle(1'b1, mk(2'd1, 4'b0010, 5'd4, 32'd0, 2'd1, 1'b0, 32'd0), 1'b0, 32'd0);
        cycle(1'b1, mk(2'd0, 4'd0, 5'd6, 32'h55, 2'd0, 1'b0, 32'd0), 1'b1, 32'hDEAD_BEEF);
        check("mis_pulse", misalign_err, 1);
        check("mis_no_wb", wb_en, 0);
        cycle(1'b0, idle, 1'b0, 32'd0);
        check("post_mis_dat", wb_dat, 32'h55);

        ld = mk(2'd1, 4'b0010, 5'd7, 32'd0, 2'd0, 1'b0, 32'd0);
        cycle(1'b1, ld, 1'b0, 32'd0);
        for (int i = 0; i < 3; i++) cycle(1'b1, mk(2'd0, 4'd0, 5'(8 + i), 32'(i), 2'd0, 1'b0, 32'd0), 1'b0, 32'd0);
        cycle(1'b1, mk(2'd0, 4'd0, 5'd20, 32'd99, 2'd0, 1'b0, 32'd0), 1'b0, 32'd0);
        check("full_rdy", in_ready, 0);
        cycle(1'b0, idle, 1'b1, 32'hCAFE_F00D);
        check("full_ld_dat", wb_dat, 32'hCAFE_F00D);
        check("full_rdy_back", in_ready, 1);
        for (int i = 0; i < 3; i++) cycle(1'b0, idle, 1'b0, 32'd0);

        cycle(1'b1, ld, 1'b0, 32'd0);
        cycle(1'b1, mk(2'd3, 4'd0, 5'd1, 32'h100, 2'd0, 1'b0, 32'h400), 1'b0, 32'd0);
        cycle(1'b1, mk(2'd0, 4'd0, 5'd9, 32'h9, 2'd0, 1'b0, 32'd0), 1'b0, 32'd0);
        cycle(1'b1, mk(2'd0, 4'd0, 5'd10, 32'hA, 2'd0, 1'b0, 32'd0), 1'b0, 32'd0);
        cycle(1'b0, idle, 1'b1, 32'h1);
        cycle(1'b1, mk(2'd0, 4'd0, 5'd11, 32'hB, 2'd0, 1'b0, 32'd0), 1'b0, 32'd0);
        check("jmp_rd", wb_rd, 1);
        check("jmp_dat", wb_dat, 32'h100);
        check("jmp_redir", redir_valid, 1);
        check("jmp_addr", redir_addr, 32'h400);
        check("jmp_flush", flush_out, 1);
        for (int i = 0; i < 3; i++) cycle(1'b0, idle, 1'b0, 32'd0);

        cycle(1'b1, ld, 1'b0, 32'd0);
        for (int i = 0; i < 3; i++) cycle(1'b1, mk(2'd0, 4'd0, 5'd12, 32'd7, 2'd0, 1'b0, 32'd0), 1'b0, 32'd0);
        do_reset();
        check("rst_rdy", in_ready, 1);
        cycle(1'b0, idle, 1'b1, 32'h7777_7777);
        check("rst_no_wb", wb_en, 0);

        for (int n = 0; n < 3000; n++) begin
            r = mk(2'($urandom), 4'($urandom), 5'($urandom), $urandom, 2'($urandom),
                   1'($urandom), $urandom);
            cycle(($urandom % 3) != 0, r, 1'($urandom), $urandom);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
